// File: rtl/board_pkg.sv
// board_pkg: shared cell/state types, board geometry and index helpers
package board_pkg;

    localparam int BOARD_DIM = 9;
    localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
    localparam int PKT_BITS  = 2 * NUM_CELLS;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        BLACK   = 2'b01,
        WHITE   = 2'b10,
        INVALID = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic logic [3:0] idx_to_row(input logic [6:0] idx);
        return 4'(idx / 7'(BOARD_DIM));
    endfunction

    function automatic logic [3:0] idx_to_col(input logic [6:0] idx);
        return 4'(idx % 7'(BOARD_DIM));
    endfunction

endpackage

// File: rtl/board_capture_if.sv
// board_capture_if: receiver payload, display read port and status signals
interface board_capture_if;
    import board_pkg::*;

    logic [PKT_BITS-1:0] data_in;
    logic                ready_in;
    logic [3:0]          rd_row;
    logic [3:0]          rd_col;
    logic [1:0]          rd_cell;
    logic                busy;
    logic                update_valid;
    logic                move_valid;
    logic [3:0]          move_row;
    logic [3:0]          move_col;
    logic [1:0]          move_colour;
    logic [6:0]          black_count;
    logic [6:0]          white_count;
    logic                pkt_err;
    logic                pkt_drop;

    modport slave (
        input  data_in, ready_in, rd_row, rd_col,
        output rd_cell, busy, update_valid, move_valid, move_row, move_col,
               move_colour, black_count, white_count, pkt_err, pkt_drop
    );

    modport master (
        output data_in, ready_in, rd_row, rd_col,
        input  rd_cell, busy, update_valid, move_valid, move_row, move_col,
               move_colour, black_count, white_count, pkt_err, pkt_drop
    );

endinterface

// File: rtl/board_rd_port.sv
// board_rd_port: bounds-checked combinational cell read from a packed board
module board_rd_port
    import board_pkg::*;
(
    input  logic [PKT_BITS-1:0] board_i,
    input  logic [3:0]          row_i,
    input  logic [3:0]          col_i,
    output logic [1:0]          cell_o
);

    logic [7:0] idx;
    logic       in_range;

    assign in_range = (row_i < 4'(BOARD_DIM)) && (col_i < 4'(BOARD_DIM));
    assign idx      = 8'(row_i) * 8'(BOARD_DIM) + 8'(col_i);
    assign cell_o   = in_range ? board_i[{idx, 1'b0} +: 2] : 2'b00;

endmodule

// File: rtl/board_capture.sv
// board_capture: validate, diff and commit 9x9 board snapshots from the receiver
module board_capture
    import board_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    board_capture_if.slave  bus
);

    state_t              state_q;
    logic                ready_last_q;
    logic [PKT_BITS-1:0] shadow_q;
    logic [PKT_BITS-1:0] board_q;
    logic [6:0]          idx_q;
    logic                err_q;
    logic [6:0]          diff_cnt_q;
    logic [6:0]          diff_idx_q;
    cell_t               diff_old_q;
    cell_t               diff_new_q;
    logic [6:0]          black_acc_q;
    logic [6:0]          white_acc_q;
    logic                update_valid_q;
    logic                move_valid_q;
    logic [3:0]          move_row_q;
    logic [3:0]          move_col_q;
    logic [1:0]          move_colour_q;
    logic [6:0]          black_count_q;
    logic [6:0]          white_count_q;
    logic                pkt_err_q;
    logic                pkt_drop_q;
    logic                capture;
    logic [1:0]          bd_raw;
    cell_t               sh_cell;
    cell_t               bd_cell;

    assign capture = bus.ready_in & ~ready_last_q;
    assign sh_cell = cell_t'(shadow_q[{idx_q, 1'b0} +: 2]);
    assign bd_cell = cell_t'(bd_raw);

    board_rd_port u_scan_rd (
        .board_i (board_q),
        .row_i   (idx_to_row(idx_q)),
        .col_i   (idx_to_col(idx_q)),
        .cell_o  (bd_raw)
    );

    board_rd_port u_disp_rd (
        .board_i (board_q),
        .row_i   (bus.rd_row),
        .col_i   (bus.rd_col),
        .cell_o  (bus.rd_cell)
    );

    assign bus.busy         = state_q != IDLE;
    assign bus.update_valid = update_valid_q;
    assign bus.move_valid   = move_valid_q;
    assign bus.move_row     = move_row_q;
    assign bus.move_col     = move_col_q;
    assign bus.move_colour  = move_colour_q;
    assign bus.black_count  = black_count_q;
    assign bus.white_count  = white_count_q;
    assign bus.pkt_err      = pkt_err_q;
    assign bus.pkt_drop     = pkt_drop_q;

    // Capture on ready rising edge, scan one cell per cycle, then commit or reject
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            ready_last_q   <= 1'b1;
            shadow_q       <= '0;
            board_q        <= '0;
            idx_q          <= '0;
            err_q          <= 1'b0;
            diff_cnt_q     <= '0;
            diff_idx_q     <= '0;
            diff_old_q     <= EMPTY;
            diff_new_q     <= EMPTY;
            black_acc_q    <= '0;
            white_acc_q    <= '0;
            update_valid_q <= 1'b0;
            move_valid_q   <= 1'b0;
            move_row_q     <= '0;
            move_col_q     <= '0;
            move_colour_q  <= '0;
            black_count_q  <= '0;
            white_count_q  <= '0;
            pkt_err_q      <= 1'b0;
            pkt_drop_q     <= 1'b0;
        end else begin
            ready_last_q   <= bus.ready_in;
            update_valid_q <= 1'b0;
            move_valid_q   <= 1'b0;
            pkt_err_q      <= 1'b0;
            pkt_drop_q     <= capture && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        shadow_q    <= bus.data_in;
                        idx_q       <= '0;
                        err_q       <= 1'b0;
                        diff_cnt_q  <= '0;
                        black_acc_q <= '0;
                        white_acc_q <= '0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (sh_cell == INVALID) err_q <= 1'b1;
                    if (sh_cell != bd_cell) begin
                        diff_cnt_q <= diff_cnt_q + 7'd1;
                        diff_idx_q <= idx_q;
                        diff_old_q <= bd_cell;
                        diff_new_q <= sh_cell;
                    end
                    if (sh_cell == BLACK) black_acc_q <= black_acc_q + 7'd1;
                    if (sh_cell == WHITE) white_acc_q <= white_acc_q + 7'd1;
                    idx_q <= idx_q + 7'd1;
                    if (idx_q == 7'(NUM_CELLS - 1)) state_q <= DONE;
                end
                DONE: begin
                    if (err_q) begin
                        pkt_err_q <= 1'b1;
                    end else begin
                        board_q        <= shadow_q;
                        black_count_q  <= black_acc_q;
                        white_count_q  <= white_acc_q;
                        update_valid_q <= 1'b1;
                        if (diff_cnt_q == 7'd1 && diff_old_q == EMPTY && diff_new_q != EMPTY) begin
                            move_valid_q  <= 1'b1;
                            move_row_q    <= idx_to_row(diff_idx_q);
                            move_col_q    <= idx_to_col(diff_idx_q);
                            move_colour_q <= diff_new_q;
                        end
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/board_capture.md
Name: board_capture

Overview:
- Sits directly downstream of the UART packet receiver. Consumes its 162-bit payload and its ready level.
- The payload is a 9x9 board: 81 cells, 2 bits each.
- On each completed packet the block validates the snapshot, diffs it against the committed board, and commits it.
- It reports a single newly placed stone, stone counts, and errors, and serves a random-access cell read port to the display logic.

Parameters:
- BOARD_DIM, 9, cells per row/column
- NUM_CELLS, 81, BOARD_DIM*BOARD_DIM
- PKT_BITS, 162, 2*NUM_CELLS

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- data_in  in  162  receiver payload; cell k (k = row*9 + col) at bits [2k+1:2k]
- ready_in  in  1  receiver idle level; 0->1 transition marks packet complete
- rd_row  in  4  display read row
- rd_col  in  4  display read column
- rd_cell  out  2  committed cell at (rd_row, rd_col), combinational
- busy  out  1  high while a snapshot is being processed
- update_valid  out  1  one-cycle pulse: snapshot committed
- move_valid  out  1  one-cycle pulse: exactly one stone added
- move_row  out  4  row of added stone
- move_col  out  4  column of added stone
- move_colour  out  2  colour of added stone (01/10)
- black_count  out  7  black stones on committed board
- white_count  out  7  white stones on committed board
- pkt_err  out  1  one-cycle pulse: snapshot rejected
- pkt_drop  out  1  one-cycle pulse: packet arrived while busy

Behaviour:
- Clocking/reset: one clock (clk_in); reset rst_in is synchronous, active-high.
- Cell codes: 00 empty, 01 black, 10 white, 11 invalid.
- Reset values:
  - Board all 00; all pulses 0; busy 0.
  - move_row/col/colour 0; black_count/white_count 0.
  - State IDLE; ready_last 1, so a high ready_in after reset does not trigger a capture.
- Edge detect: capture = ready_in & ~ready_last; ready_last registered every cycle.
- States:
  - IDLE: on capture edge E0, latch data_in into the shadow register, idx <= 0, clear scan accumulators, go to SCAN.
  - SCAN: one cell per cycle, idx 0..80. Accumulators:
    - err if shadow cell == 11.
    - If shadow != board cell: diff_cnt++ (7-bit, saturating not required, max 81); record idx, old and new code.
    - Per-colour stone counts of the shadow.
    - At idx == 80, go to DONE.
  - DONE (one cycle, at edge E82), registered:
    - If err: pkt_err = 1; board, counts and move outputs unchanged.
    - Else: board <= shadow, counts <= accumulators, update_valid = 1.
    - If additionally diff_cnt == 1 and old == 00 and new != 00: move_valid = 1, move_row = idx/9, move_col = idx%9, move_colour = new.
    - Return to IDLE.
- busy = (state != IDLE).
- Pulses are high exactly one cycle, the cycle following E82. rd_cell reflects the new board in that same cycle.
- move_row/col/colour hold their values until the next move_valid.
- diff_cnt == 0, > 1, or a removal/recolour: commit proceeds, move_valid stays 0.
- Capture edge while busy: snapshot ignored, pkt_drop pulses next cycle, the in-flight scan is unaffected.
- Capture edge in the same cycle as DONE: treated as busy (dropped).
- Read port: rd_row > 8 or rd_col > 8 returns 00. Index = rd_row*9 + rd_col; no clock latency.
- rst_in mid-SCAN: abort immediately, reset values as above, no pulses.

Decomposition:
- board_pkg holds:
  - cell_t enum (EMPTY, BLACK, WHITE, INVALID).
  - BOARD_DIM, NUM_CELLS, PKT_BITS.
  - State enum (IDLE, SCAN, DONE).
  - idx_to_row/idx_to_col functions.
- One sub-module, board_rd_port: combinational bounds-check plus 81:1 cell mux for the display read path. Also reused for the scan-side read of board[idx].

Test Plan:
- Reset, then hold ready_in=1 for 200 cycles -> no update_valid, busy=0, all counts 0, rd_cell(4,4)=00.
- data_in with cell 40 = 01, ready_in 0->1 -> busy for 82 cycles, then:
  - update_valid, move_valid, move_row=4, move_col=4, move_colour=01 in the same cycle;
  - black_count=1; rd_cell(4,4)=01.
- Next packet adds cell 0 = 10, cell 40 kept -> move_valid, row 0, col 0, colour 10; white_count=1, black_count=1.
- Packet with cell 80 = 11 -> pkt_err pulse only; board, counts and move outputs unchanged; rd_cell(8,8)=00.
- Packet that removes cell 40 and adds cells 1 and 2 -> update_valid=1, move_valid=0, counts updated; second 0->1 edge 10 cycles after the first -> pkt_drop, first result unaffected.
- Assert rst_in at SCAN idx 30 -> no pulses, board cleared; rd_row=9, rd_col=0 -> rd_cell=00.
